max7219_rx: RTL and testbench

- Serial receiver/decoder for the MAX7219 3-wire display link (sck/din/load) that our display driver transmits on.
- Oversamples the link on the system clock, deserializes 16-bit frames and decodes them into the MAX7219 register file (digits, decode mode, intensity, scan limit, shutdown, display test).
- Serves as the on-chip display-emulation target and as the checker model for the display driver's output frames.

---
 rtl/max7219_pkg.sv | 18 +
 rtl/max7219_rx_sync_edge.sv | 31 +++
 rtl/max7219_rx.sv | 108 ++++++++++
 tb/tb_max7219_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared MAX7219 link definitions: register addresses and frame geometry.
// Imported by both the display transmitter and the link receiver.
package max7219_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

endpackage

// File: rtl/max7219_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous link pin, plus a registered
// copy of the synchronized level that yields single-clock rise/fall pulses.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              level_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d};
            level_d <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 3-wire link receiver: oversamples sck/din/load on the system clock,
// deserializes 16-bit frames and mirrors the MAX7219 register file.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int DIGIT_NUM   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   max_sck,
    input  logic                   max_din,
    input  logic                   max_load,
    output logic                   max_dout,
    output logic [DIGIT_NUM*8-1:0] digits,
    output logic [7:0]             decode_mode,
    output logic [3:0]             intensity,
    output logic [2:0]             scan_limit,
    output logic                   shutdown_n,
    output logic                   display_test,
    output logic                   frame_valid,
    output logic [3:0]             frame_addr,
    output logic [7:0]             frame_data,
    output logic                   frame_err
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic din_s, din_rise_unused, din_fall_unused;
    logic load_rise, load_fall, load_lvl_unused;

    logic [FRAME_BITS-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]      bit_cnt, cnt_base, cnt_next;
    logic                  cnt_short;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clock(clock), .reset(reset), .d(max_sck),
        .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clock(clock), .reset(reset), .d(max_din),
        .level(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clock(clock), .reset(reset), .d(max_load),
        .level(load_lvl_unused), .rise(load_rise), .fall(load_fall)
    );

    // Same-clock collisions resolve as: clear counter, then shift/count, then latch.
    always_comb begin
        cnt_base   = load_fall ? '0 : bit_cnt;
        cnt_next   = sck_rise ? sat_inc(cnt_base) : cnt_base;
        shift_next = sck_rise ? {shift_reg[FRAME_BITS-2:0], din_s} : shift_reg;
        cnt_short  = (cnt_next < FULL_CNT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            max_dout     <= 1'b0;
            digits       <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
            frame_valid  <= 1'b0;
            frame_addr   <= '0;
            frame_data   <= '0;
            frame_err    <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt     <= cnt_next;
            frame_valid <= load_rise;
            if (sck_fall)
                max_dout <= shift_reg[FRAME_BITS-1];
            if (load_rise) begin
                frame_addr <= shift_next[11:8];
                frame_data <= shift_next[7:0];
                frame_err  <= cnt_short;
            end
            if (load_rise && !cnt_short) begin
                case (shift_next[11:8])
                    ADDR_NOOP:      ;
                    ADDR_DECODE:    decode_mode  <= shift_next[7:0];
                    ADDR_INTENSITY: intensity    <= shift_next[3:0];
                    ADDR_SCANLIMIT: scan_limit   <= shift_next[2:0];
                    ADDR_SHUTDOWN:  shutdown_n   <= shift_next[0];
                    ADDR_TEST:      display_test <= shift_next[0];
                    default: begin
                        for (int d = 0; d < DIGIT_NUM; d++)
                            if (shift_next[11:8] == 4'(d) + ADDR_DIGIT0)
                                digits[8*d +: 8] <= shift_next[7:0];
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_max7219_rx.sv
// Self-checking bench for max7219_rx: table-driven frames, collision corner
// cases and randomized frames against a bit-history reference model.
module tb_max7219_rx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        max_sck = 1'b0;
    logic        max_din = 1'b0;
    logic        max_load = 1'b0;
    logic        max_dout;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n;
    logic        display_test;
    logic        frame_valid;
    logic [3:0]  frame_addr;
    logic [7:0]  frame_data;
    logic        frame_err;

    max7219_rx #(.DIGIT_NUM(8), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset),
        .max_sck(max_sck), .max_din(max_din), .max_load(max_load),
        .max_dout(max_dout), .digits(digits), .decode_mode(decode_mode),
        .intensity(intensity), .scan_limit(scan_limit), .shutdown_n(shutdown_n),
        .display_test(display_test), .frame_valid(frame_valid),
        .frame_addr(frame_addr), .frame_data(frame_data), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: every bit shifted since reset, bits since last load fall,
    // and the register file.
    bit          hist[$];
    int          m_cnt;
    logic [63:0] m_digits;
    logic [7:0]  m_decode;
    logic [3:0]  m_int;
    logic [2:0]  m_scan;
    logic        m_shut, m_test;
    logic        m_err;
    logic [3:0]  m_addr;
    logic [7:0]  m_data;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        logic        exp_err;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_reset();
        hist.delete();
        m_cnt = 0;
        m_digits = '0; m_decode = '0; m_int = '0; m_scan = '0;
        m_shut = 1'b0; m_test = 1'b0;
    endtask

    task automatic model_rise(input bit b);
        hist.push_back(b);
        m_cnt++;
    endtask

    function automatic logic model_dout();
        int k = hist.size();
        return (k >= 16) ? hist[k-16] : 1'b0;
    endfunction

    task automatic model_latch();
        logic [15:0] w = '0;
        int k = hist.size();
        for (int i = 0; i < 16; i++) begin
            int idx = k - 16 + i;
            w = {w[14:0], (idx >= 0) ? hist[idx] : 1'b0};
        end
        m_err  = (m_cnt < 16);
        m_addr = w[11:8];
        m_data = w[7:0];
        if (!m_err) begin
            if (m_addr >= 4'd1 && m_addr <= 4'd8) m_digits[8*(int'(m_addr)-1) +: 8] = m_data;
            else if (m_addr == 4'h9) m_decode = m_data;
            else if (m_addr == 4'hA) m_int = m_data[3:0];
            else if (m_addr == 4'hB) m_scan = m_data[2:0];
            else if (m_addr == 4'hC) m_shut = m_data[0];
            else if (m_addr == 4'hF) m_test = m_data[0];
        end
    endtask

    task automatic check_regs();
        chk("digits", digits, m_digits);
        chk("decode_mode", decode_mode, m_decode);
        chk("intensity", intensity, m_int);
        chk("scan_limit", scan_limit, m_scan);
        chk("shutdown_n", shutdown_n, m_shut);
        chk("display_test", display_test, m_test);
    endtask

    task automatic send_bit(input bit b);
        max_din = b;
        wait_clk(3);
        max_sck = 1'b1;
        model_rise(b);
        wait_clk(3);
        max_sck = 1'b0;
        wait_clk(3);
        chk("max_dout", max_dout, model_dout());
    endtask

    task automatic latch_check();
        int n = 0;
        max_load = 1'b1;
        model_latch();
        while (frame_valid !== 1'b1 && n < 10) begin
            wait_clk(1);
            n++;
        end
        checks++;
        if (frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL frame_valid_timeout: got %b expected 1 within 10 clocks", frame_valid);
        end else begin
            chk("frame_err", frame_err, m_err);
            chk("frame_addr", frame_addr, m_addr);
            chk("frame_data", frame_data, m_data);
            wait_clk(1);
            chk("frame_valid_width", frame_valid, 1'b0);
        end
        check_regs();
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits);
        if (max_load === 1'b1) m_cnt = 0;
        max_load = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) send_bit(word[i]);
        latch_check();
    endtask

    task automatic check_reset_state();
        chk("rst_digits", digits, 64'h0);
        chk("rst_decode", decode_mode, 8'h0);
        chk("rst_intensity", intensity, 4'h0);
        chk("rst_scan", scan_limit, 3'h0);
        chk("rst_shutdown_n", shutdown_n, 1'b0);
        chk("rst_test", display_test, 1'b0);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_addr", frame_addr, 4'h0);
        chk("rst_data", frame_data, 8'h0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_dout", max_dout, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [31:0] w;
        int nb;

        vecs[0] = '{32'h0000_0C01, 16, 1'b0, 4'hC, 8'h01};
        vecs[1] = '{32'h0000_0A07, 16, 1'b0, 4'hA, 8'h07};
        vecs[2] = '{32'h0000_0112, 16, 1'b0, 4'h1, 8'h12};
        vecs[3] = '{32'h0000_08AB, 16, 1'b0, 4'h8, 8'hAB};
        vecs[4] = '{32'h0000_00C0, 12, 1'b1, 4'h0, 8'hC0};
        vecs[5] = '{32'h000F_0F01, 20, 1'b0, 4'hF, 8'h01};
        vecs[6] = '{32'h0000_0D55, 16, 1'b0, 4'hD, 8'h55};
        vecs[7] = '{32'h0B05_0C01, 32, 1'b0, 4'hC, 8'h01};

        model_reset();
        #1 reset = 1'b0;
        wait_clk(3);
        check_reset_state();
        reset = 1'b1;
        wait_clk(2);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].word, vecs[i].nbits);
            chk("tbl_err", frame_err, vecs[i].exp_err);
            chk("tbl_addr", frame_addr, vecs[i].exp_addr);
            chk("tbl_data", frame_data, vecs[i].exp_data);
        end
        chk("plan_digits", digits, 64'hAB00_0000_0000_0012);
        chk("plan_intensity", intensity, 4'h7);
        chk("plan_scan", scan_limit, 3'h0);
        chk("plan_shutdown_n", shutdown_n, 1'b1);
        chk("plan_test", display_test, 1'b1);

        // Reset in the middle of a frame, then a clean frame.
        m_cnt = 0;
        max_load = 1'b0;
        w = 32'h0000_0A0F;
        for (int i = 15; i >= 8; i--) send_bit(w[i]);
        reset = 1'b0;
        model_reset();
        wait_clk(2);
        check_reset_state();
        reset = 1'b1;
        wait_clk(2);
        send_frame(32'h0000_0A03, 16);
        chk("postrst_intensity", intensity, 4'h3);
        chk("postrst_err", frame_err, 1'b0);

        // sck rise and load rise on the same clock: latch sees the 16th bit.
        m_cnt = 0;
        max_load = 1'b0;
        w = 32'h0000_0B06;
        for (int i = 15; i >= 1; i--) send_bit(w[i]);
        max_din = w[0];
        wait_clk(3);
        max_sck = 1'b1;
        model_rise(w[0]);
        latch_check();
        max_sck = 1'b0;
        wait_clk(3);
        chk("coll_rise_dout", max_dout, model_dout());
        chk("coll_rise_scan", scan_limit, 3'h6);
        chk("coll_rise_err", frame_err, 1'b0);

        // sck rise and load fall on the same clock: that bit counts as bit 1.
        w = 32'h0000_0905;
        max_din = w[15];
        wait_clk(3);
        max_sck = 1'b1;
        max_load = 1'b0;
        m_cnt = 0;
        model_rise(w[15]);
        wait_clk(3);
        max_sck = 1'b0;
        wait_clk(3);
        chk("coll_fall_dout", max_dout, model_dout());
        for (int i = 14; i >= 0; i--) send_bit(w[i]);
        latch_check();
        chk("coll_fall_err", frame_err, 1'b0);
        chk("coll_fall_decode", decode_mode, 8'h05);

        // Randomized frames, mostly full-length, some short or long.
        for (int i = 0; i < 25; i++) begin
            w  = $urandom;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 24)) : 16;
            send_frame(w, nb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
